// File: rtl/fn_eval_sched_if.sv
// Request/response bundle between the requesters and the shared function-evaluation scheduler.
// The scheduler uses the slave modport; the requesters and consumer use master.
interface fn_eval_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_op;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic [2:0]        out_tag;
  logic              out_err;

  modport master (
    output req_valid, req_op, req_a, req_b, out_ready,
    input  req_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, out_ready,
    output req_ready, out_valid, out_data, out_tag, out_err
  );
endinterface

// File: rtl/fn_eval_sched.sv
// Round-robin arbiter feeding a 2-stage (issue, result) function-evaluation pipeline
// with tagged results and full-stall backpressure.
module fn_eval_sched #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              reset,
  fn_eval_sched_if.slave    bus,
  output logic              busy
);

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] tag;
  } s1_t;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] tag;
    logic       err;
  } s2_t;

  logic [NREQ-1:0][2:0] op_v;
  logic [NREQ-1:0][7:0] a_v;
  logic [NREQ-1:0][7:0] b_v;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_v[i] = bus.req_op[3*i +: 3];
    assign a_v[i]  = bus.req_a[8*i +: 8];
    assign b_v[i]  = bus.req_b[8*i +: 8];
  end

  logic       s1_v_q, s1_v_d;
  s1_t        s1_q, s1_d;
  logic       s2_v_q, s2_v_d;
  s2_t        s2_q, s2_d;
  logic [2:0] rr_q, rr_d;

  logic       s2_load, s1_free, grant, gnt_found;
  logic [2:0] gnt_idx;
  s1_t        sel;

  assign s2_load = s1_v_q && (!s2_v_q || bus.out_ready);
  assign s1_free = !s1_v_q || s2_load;

  // Two descending passes: the lowest index >= rr wins; otherwise the lowest index below rr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sel       = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (bus.req_valid[i] && (3'(i) < rr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = 3'(i);
        sel       = '{op: op_v[i], a: a_v[i], b: b_v[i], tag: 3'(i)};
      end
    end
    for (int i = NREQ-1; i >= 0; i--) begin
      if (bus.req_valid[i] && (3'(i) >= rr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = 3'(i);
        sel       = '{op: op_v[i], a: a_v[i], b: b_v[i], tag: 3'(i)};
      end
    end
  end

  assign grant = gnt_found && s1_free && !reset;

  for (genvar i = 0; i < NREQ; i++) begin : g_ready
    assign bus.req_ready[i] = grant && (gnt_idx == 3'(i));
  end

  function automatic s2_t eval(input s1_t s);
    s2_t r;
    r      = '0;
    r.tag  = s.tag;
    case (s.op)
      3'd0: r.data = {7'b0, s.a[0] ^ s.b[0]};
      3'd1: r.data = {7'b0, s.a[0] & s.b[0]};
      3'd2: r.data = {4'b0, s.a[3:0] & s.b[3:0]};
      3'd3: r.data = {4'b0, {3'b0, s.a[0]} & s.b[3:0]};
      3'd4: r.data = {7'b0, $signed(s.a[3:0]) < $signed(s.b[3:0])};
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  always_comb begin
    s1_v_d = s1_v_q;
    s1_d   = s1_q;
    s2_v_d = s2_v_q;
    s2_d   = s2_q;
    rr_d   = rr_q;

    // S2 keeps its last contents after draining so the outputs never glitch.
    if (s2_load) begin
      s2_v_d = 1'b1;
      s2_d   = eval(s1_q);
    end else if (s2_v_q && bus.out_ready) begin
      s2_v_d = 1'b0;
    end

    if (grant) begin
      s1_v_d = 1'b1;
      s1_d   = sel;
      rr_d   = (gnt_idx == 3'(NREQ-1)) ? 3'd0 : gnt_idx + 3'd1;
    end else if (s2_load) begin
      s1_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q <= 1'b0;
      s1_q   <= '0;
      s2_v_q <= 1'b0;
      s2_q   <= '0;
      rr_q   <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s1_q   <= s1_d;
      s2_v_q <= s2_v_d;
      s2_q   <= s2_d;
      rr_q   <= rr_d;
    end
  end

  assign bus.out_valid = s2_v_q;
  assign bus.out_data  = s2_q.data;
  assign bus.out_tag   = s2_q.tag;
  assign bus.out_err   = s2_q.err;
  assign busy          = s1_v_q || s2_v_q;

endmodule

// File: tb/tb_fn_eval_sched.sv
// Scoreboard bench for fn_eval_sched: handshakes push hand-computed expectations,
// an independent monitor pops and compares on each accepted result.
module tb_fn_eval_sched;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  always #5 clk = ~clk;

  fn_eval_sched_if #(.NREQ(NREQ)) bus();

  fn_eval_sched #(.NREQ(NREQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  typedef struct {
    logic [2:0] tag;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_d [NREQ];
  logic       exp_e [NREQ];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expectation capture at each completed handshake.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i])
          sb.push_back('{tag: 3'(i), data: exp_d[i], err: exp_e[i]});
      end
    end
  end

  // Result monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got tag %0d with nothing expected", bus.out_tag);
      end else begin
        e = sb.pop_front();
        chk("out_tag",  32'(bus.out_tag),  32'(e.tag));
        chk("out_data", 32'(bus.out_data), 32'(e.data));
        chk("out_err",  32'(bus.out_err),  32'(e.err));
      end
    end
  end

  task automatic set_req(input int r, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] ed, input logic ee);
    bus.req_op[3*r +: 3] = op;
    bus.req_a[8*r +: 8]  = a;
    bus.req_b[8*r +: 8]  = b;
    exp_d[r]             = ed;
    exp_e[r]             = ee;
  endtask

  task automatic issue(input int r, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] ed, input logic ee);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    set_req(r, op, a, b, ed, ee);
    bus.req_valid[r] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.req_ready[r]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("grant_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    bus.req_valid[r] = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!busy) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) chk("idle_timeout", 32'(idle), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] hd;
    logic [2:0] ht;
    int         grants;

    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      exp_d[i] = '0;
      exp_e[i] = 1'b0;
    end
    bus.req_valid[0] = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_tag",   32'(bus.out_tag),   32'd0);
    chk("rst_out_err",   32'(bus.out_err),   32'd0);
    chk("rst_busy",      32'(busy),          32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    reset         = 1'b0;
    bus.out_ready = 1'b1;

    // Latency: signed compare -1 < 1
    issue(2, 3'd4, 8'h0F, 8'h01, 8'h01, 1'b0);
    @(negedge clk);
    chk("lat_n1_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_n2_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_n2_data",  32'(bus.out_data),  32'h01);
    chk("lat_n2_tag",   32'(bus.out_tag),   32'd2);
    chk("lat_n2_err",   32'(bus.out_err),   32'd0);

    // Function and truncation vectors
    issue(2, 3'd4, 8'h07, 8'hF8, 8'h00, 1'b0);
    issue(0, 3'd2, 8'hFF, 8'h3C, 8'h0C, 1'b0);
    issue(1, 3'd3, 8'hFF, 8'hFF, 8'h01, 1'b0);
    issue(3, 3'd0, 8'h02, 8'h03, 8'h01, 1'b0);
    issue(0, 3'd6, 8'h5A, 8'hA5, 8'h00, 1'b1);
    issue(1, 3'd1, 8'h03, 8'hFE, 8'h00, 1'b0);
    issue(3, 3'd4, 8'h88, 8'h17, 8'h01, 1'b0);
    wait_idle();
    chk("vec_drained", 32'(sb.size()), 32'd0);

    // Round-robin with every requester valid, starting from rr = 0
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    set_req(0, 3'd2, 8'hA5, 8'h0F, 8'h05, 1'b0);
    set_req(1, 3'd0, 8'h01, 8'h00, 8'h01, 1'b0);
    set_req(2, 3'd4, 8'h08, 8'h07, 8'h01, 1'b0);
    set_req(3, 3'd7, 8'h11, 8'h22, 8'h00, 1'b1);
    bus.req_valid = '1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("rr_grant_%0d", k), 32'(bus.req_ready), 32'd1 << (k % 4));
      if (k >= 2) begin
        chk($sformatf("rr_valid_%0d", k), 32'(bus.out_valid), 32'd1);
        chk($sformatf("rr_tag_%0d", k),   32'(bus.out_tag),   32'((k - 2) % 4));
      end
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_idle();
    chk("rr_drained", 32'(sb.size()), 32'd0);

    // Backpressure: out_ready low for 5 cycles from an empty pipeline
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.req_valid = '1;
    grants = 0;
    hd     = '0;
    ht     = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (|bus.req_ready) grants++;
      if (k == 2) begin
        hd = bus.out_data;
        ht = bus.out_tag;
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
      end else if (k > 2) begin
        chk($sformatf("stall_data_hold_%0d", k), 32'(bus.out_data), 32'(hd));
        chk($sformatf("stall_tag_hold_%0d", k),  32'(bus.out_tag),  32'(ht));
      end
    end
    chk("stall_grants",    32'(grants),        32'd2);
    chk("stall_ready_low", 32'(bus.req_ready), 32'd0);
    chk("stall_inflight",  32'(sb.size()),     32'd2);
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    wait_idle();
    chk("stall_drained", 32'(sb.size()), 32'd0);

    // Reset while both stages are full
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.req_valid = '1;
    repeat (3) @(negedge clk);
    chk("full_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("post_rst_busy",  32'(busy),          32'd0);
    chk("post_rst_grant", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_idle();
    chk("final_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
